// File: rtl/fpa_pkg.sv
// Shared definitions for the 8-bit floating-point adder control path:
// FSM state encoding, error-source codes and number-format widths.
package fpa_pkg;

    localparam int EXP_W   = 4;
    localparam int MANT_W  = 3;
    localparam int WMANT_W = 5;

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        LOAD    = 4'd1,
        ADD     = 4'd2,
        ADD_CHK = 4'd3,
        NORM_LD = 4'd4,
        NORM    = 4'd5,
        DONE_LD = 4'd6,
        DONE    = 4'd7,
        ERR     = 4'd8
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ADD     = 2'b01;
    localparam logic [1:0] ERR_NORM    = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

endpackage

// File: rtl/fpa_controller.sv
// Control FSM sequencing the 8-bit FP adder datapath: load, add, exception
// check, iterative normalise with a bounded step count, and result capture.
module fpa_controller
    import fpa_pkg::*;
#(
    parameter int MAX_NORM_STEPS = 4,
    parameter int CNT_W          = $clog2(MAX_NORM_STEPS + 1)
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               start,
    input  logic               add_except,
    input  logic               norm_except,
    input  logic [WMANT_W-1:0] mant,
    output logic               load_en,
    output logic               add_en,
    output logic               norm_en,
    output logic               done_en,
    output logic               norm_load,
    output logic               shift_left,
    output logic               shift_right,
    output logic               ready,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [1:0]         err_src,
    output logic [3:0]         state_dbg
);

    // Handshake: start is taken only on an edge where ready=1 (IDLE); busy is
    // the complement of ready; done pulses for exactly one cycle per accepted
    // start, err qualifies that pulse, and err_src holds until the next start.

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [1:0]       err_src_next;
    logic             unused_mant_lo;

    // Only the two top bits of the working mantissa steer normalisation.
    assign unused_mant_lo = ^mant[2:0];
    assign state_dbg      = state;

    always_ff @(posedge clk) begin
        if (clr) begin
            state   <= IDLE;
            cnt     <= '0;
            err_src <= ERR_NONE;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            err_src <= err_src_next;
        end
    end

    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        err_src_next = err_src;
        load_en      = 1'b0;
        add_en       = 1'b0;
        norm_en      = 1'b0;
        done_en      = 1'b0;
        norm_load    = 1'b0;
        shift_left   = 1'b0;
        shift_right  = 1'b0;
        ready        = 1'b0;
        done         = 1'b0;
        err          = 1'b0;
        busy         = (state != IDLE);

        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    state_next   = LOAD;
                    err_src_next = ERR_NONE;
                end
            end
            LOAD: begin
                load_en    = 1'b1;
                state_next = ADD;
            end
            ADD: begin
                add_en     = 1'b1;
                state_next = ADD_CHK;
            end
            ADD_CHK: begin
                if (add_except) begin
                    state_next   = ERR;
                    err_src_next = ERR_ADD;
                end else begin
                    state_next = NORM_LD;
                end
            end
            NORM_LD: begin
                norm_en    = 1'b1;
                norm_load  = 1'b1;
                cnt_next   = '0;
                state_next = NORM;
            end
            NORM: begin
                // norm_en stays high so a settled mantissa simply reloads itself.
                norm_en = 1'b1;
                if (norm_except) begin
                    state_next   = ERR;
                    err_src_next = ERR_NORM;
                end else if (mant[4:3] == 2'b01) begin
                    state_next = DONE_LD;
                end else if (cnt == CNT_W'(MAX_NORM_STEPS)) begin
                    state_next   = ERR;
                    err_src_next = ERR_TIMEOUT;
                end else if (mant[4]) begin
                    shift_right = 1'b1;
                    cnt_next    = cnt + CNT_W'(1);
                end else begin
                    shift_left = 1'b1;
                    cnt_next   = cnt + CNT_W'(1);
                end
            end
            DONE_LD: begin
                done_en    = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            ERR: begin
                done       = 1'b1;
                err        = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fpa_controller.sv
// Directed and randomized check of fpa_controller against a small datapath
// model and an outcome model derived from the normalisation rules.
module tb_fpa_controller;

    logic       clk;
    logic       clr;
    logic       start;
    logic       add_except;
    logic       norm_except;
    logic [4:0] mant;
    logic       load_en, add_en, norm_en, done_en, norm_load;
    logic       shift_left, shift_right, ready, busy, done, err;
    logic [1:0] err_src;
    logic [3:0] state_dbg;

    logic [4:0] add_val;
    logic [4:0] nreg;

    int checks   = 0;
    int failures = 0;

    fpa_controller dut (
        .clk         (clk),
        .clr         (clr),
        .start       (start),
        .add_except  (add_except),
        .norm_except (norm_except),
        .mant        (mant),
        .load_en     (load_en),
        .add_en      (add_en),
        .norm_en     (norm_en),
        .done_en     (done_en),
        .norm_load   (norm_load),
        .shift_left  (shift_left),
        .shift_right (shift_right),
        .ready       (ready),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .err_src     (err_src),
        .state_dbg   (state_dbg)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // datapath model: normalise register loads the add result or shifts by one
    always @(posedge clk) begin
        if (norm_en && norm_load) nreg <= add_val;
        else if (shift_left)      nreg <= {nreg[3:0], 1'b0};
        else if (shift_right)     nreg <= {1'b0, nreg[4:1]};
    end
    assign mant = norm_en ? nreg : add_val;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_ctl"}, {23'd0, load_en, add_en, norm_en, done_en, norm_load,
                            shift_left, shift_right, done, err}, 32'd0);
        chk({tag, "_ready"}, ready, 1);
        chk({tag, "_busy"}, busy, 0);
    endtask

    function automatic int msb_pos(input logic [4:0] v);
        int p = -1;
        for (int i = 0; i < 5; i++) if (v[i]) p = i;
        return p;
    endfunction

    // One operation from acceptance to done; returns at #1 after the edge that
    // follows done (IDLE cycle) unless hold is set, in which case start stays high.
    task automatic run_op(input logic [4:0] v, input logic aexc, input logic nexc,
                          input bit noise, input bit hold);
        int cyc, n_load, n_add, n_norm, n_done_en, n_nl, n_sl, n_sr, n_both, n_idle;
        int c_load, c_add, c_nl, c_done_en, c_done;
        int e_done, e_norm, e_sl, e_sr, e_err, e_src, e_den;
        bit got_done;
        logic d_err;
        logic [1:0] d_src;
        n_load = 0; n_add = 0; n_norm = 0; n_done_en = 0; n_nl = 0;
        n_sl = 0; n_sr = 0; n_both = 0; n_idle = 0;
        c_load = 0; c_add = 0; c_nl = 0; c_done_en = 0; c_done = 0;
        got_done = 0; d_err = 0; d_src = 0;
        add_val = v; add_except = aexc; norm_except = nexc; start = 1'b1;
        @(posedge clk); #1;
        cyc = 1;
        while (!got_done && cyc <= 30) begin
            if (load_en)   begin n_load++;    c_load = cyc;    end
            if (add_en)    begin n_add++;     c_add = cyc;     end
            if (norm_load) begin n_nl++;      c_nl = cyc;      end
            if (done_en)   begin n_done_en++; c_done_en = cyc; end
            if (norm_en)     n_norm++;
            if (shift_left)  n_sl++;
            if (shift_right) n_sr++;
            if (shift_left && shift_right) n_both++;
            if (ready || !busy) n_idle++;
            if (done) begin got_done = 1; c_done = cyc; d_err = err; d_src = err_src; end
            start = got_done ? hold : (noise ? 1'($urandom_range(0, 1)) : 1'b0);
            if (!got_done) begin @(posedge clk); #1; cyc++; end
        end
        chk("done_seen", got_done, 1);

        // expected outcome from the normalisation rules
        e_sl = 0; e_sr = 0; e_den = 0;
        if (aexc) begin
            e_done = 4; e_norm = 0; e_err = 1; e_src = 1;
        end else if (nexc) begin
            e_done = 6; e_norm = 2; e_err = 1; e_src = 2;
        end else if (v == 0) begin
            e_sl = 4; e_done = 10; e_norm = 6; e_err = 1; e_src = 3;
        end else begin
            if (v[4]) e_sr = 1;
            else      e_sl = 3 - msb_pos(v);
            e_done = 7 + e_sl + e_sr; e_norm = 2 + e_sl + e_sr;
            e_err = 0; e_src = 0; e_den = 1;
        end

        chk("load_cnt", n_load, 1);
        chk("load_cyc", c_load, 1);
        chk("add_cnt", n_add, 1);
        chk("add_cyc", c_add, 2);
        chk("norm_en_cnt", n_norm, e_norm);
        chk("norm_load_cnt", n_nl, aexc ? 0 : 1);
        if (!aexc) chk("norm_load_cyc", c_nl, 4);
        chk("shl_cnt", n_sl, e_sl);
        chk("shr_cnt", n_sr, e_sr);
        chk("shift_both", n_both, 0);
        chk("busy_during_op", n_idle, 0);
        chk("done_en_cnt", n_done_en, e_den);
        if (e_den == 1) chk("done_en_cyc", c_done_en, e_done - 1);
        chk("done_cyc", c_done, e_done);
        chk("done_err", d_err, e_err);
        chk("done_src", d_src, e_src);

        if (!hold) begin
            @(posedge clk); #1;
            chk_idle("post_done");
            chk("src_hold", err_src, e_src);
        end
    endtask

    initial begin
        logic [4:0] rv;
        logic ra, rn;
        bit rnoise;

        // reset
        clr = 1'b1; start = 1'b0; add_except = 1'b0; norm_except = 1'b0; add_val = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk_idle("reset");
        chk("reset_src", err_src, 0);
        clr = 1'b0;
        @(posedge clk); #1;

        // directed: zero, right, left and double-left normalisation
        run_op(5'b01010, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op(5'b10110, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op(5'b00101, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op(5'b00010, 1'b0, 1'b0, 1'b0, 1'b0);

        // add exception, err_src must hold while idle, then clr clears it
        run_op(5'b01010, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1 chk("src_idle_hold", err_src, 1);
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        chk("clr_src", err_src, 0);
        chk_idle("clr_idle");

        // timeout and norm exception
        run_op(5'b00000, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op(5'b00101, 1'b0, 1'b1, 1'b0, 1'b0);

        // clr in NORM (stuck mantissa keeps the FSM there)
        add_val = 5'b00000; add_except = 1'b0; norm_except = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1 chk("norm_busy", busy, 1);
        chk("norm_en_mid", norm_en, 1);
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        chk_idle("clr_norm");
        chk("clr_norm_src", err_src, 0);

        // start noise during the operation, then start held across done
        run_op(5'b00010, 1'b0, 1'b0, 1'b1, 1'b0);
        run_op(5'b10110, 1'b0, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        chk_idle("hold_idle");
        run_op(5'b00101, 1'b0, 1'b0, 1'b0, 1'b0);

        // randomized operations
        for (int i = 0; i < 40; i++) begin
            rv     = 5'($urandom_range(0, 31));
            ra     = ($urandom_range(0, 7) == 0);
            rn     = ($urandom_range(0, 7) == 0);
            rnoise = 1'($urandom_range(0, 1));
            run_op(rv, ra, rn, rnoise, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
